// File: rtl/sort_stream_pkg.sv
// Shared types for the sort stream adapter: load FSM states, drain flag, lane indexing.
// No logic, so no latency.
// No backpressure of its own; the modules that import it carry the flow control.
package sort_stream_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef logic [LANE_W-1:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

    // Frame-side sequencing around one run of the sort block.
    typedef enum logic [2:0] {
        LOAD,
        KICK,
        WAIT_HI,
        WAIT_LO,
        HOLD
    } load_state_t;

    // Result buffer occupancy.
    typedef enum logic {
        EMPTY,
        DRAIN
    } drain_state_t;

endpackage

// File: rtl/sort_stream_adapter_if.sv
// Bundles the upstream stream, downstream stream and sort-block side signals of the adapter.
// No logic, so no latency.
// No backpressure of its own; in_ready/out_ready inside carry the flow control.
interface sort_stream_adapter_if #(parameter int WIDTH = 32) ();

    // upstream word stream
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    // downstream sorted stream
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    // parallel side towards the sort block
    logic [WIDTH-1:0] sort_input_0;
    logic [WIDTH-1:0] sort_input_1;
    logic [WIDTH-1:0] sort_input_2;
    logic [WIDTH-1:0] sort_input_3;
    logic             sort_kick;
    logic             sort_busy;
    logic [WIDTH-1:0] sort_output_0;
    logic [WIDTH-1:0] sort_output_1;
    logic [WIDTH-1:0] sort_output_2;
    logic [WIDTH-1:0] sort_output_3;

    // master: the adapter itself
    modport master (
        input  in_data, in_valid, out_ready, sort_busy,
        input  sort_output_0, sort_output_1, sort_output_2, sort_output_3,
        output in_ready, out_data, out_valid, out_last, sort_kick,
        output sort_input_0, sort_input_1, sort_input_2, sort_input_3
    );

    // slave: producer, consumer and sort block around the adapter
    modport slave (
        output in_data, in_valid, out_ready, sort_busy,
        output sort_output_0, sort_output_1, sort_output_2, sort_output_3,
        input  in_ready, out_data, out_valid, out_last, sort_kick,
        input  sort_input_0, sort_input_1, sort_input_2, sort_input_3
    );

endinterface

// File: rtl/sort_result_drain.sv
// Holds one sorted 4-lane result and replays it as a serial stream, lane 0 first, last on lane 3.
// Capture to out_valid: 1 cycle; then 1 word/cycle while out_ready is high.
// out_ready low freezes out_data/out_last; cap_rdy also opens on the final transfer so a new capture needs no bubble.
module sort_result_drain
    import sort_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              cap_vld,
    input  logic [NUM_LANES-1:0][WIDTH-1:0]   cap_dat,
    output logic                              cap_rdy,
    output logic [WIDTH-1:0]                  out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last
);

    drain_state_t                     st_q;
    lane_idx_t                        idx_q;
    logic [NUM_LANES-1:0][WIDTH-1:0]  res_q;
    logic                             xfer;
    logic                             last_xfer;

    assign xfer      = (st_q == DRAIN) && out_ready;
    assign last_xfer = xfer && (idx_q == LAST_LANE);

    // Buffer is free when idle, or when its final word leaves this very cycle.
    assign cap_rdy   = (st_q == EMPTY) || last_xfer;

    assign out_valid = (st_q == DRAIN);
    assign out_data  = out_valid ? res_q[idx_q] : '0;
    assign out_last  = out_valid && (idx_q == LAST_LANE);

    // Capture takes priority over the last transfer; otherwise step through the lanes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st_q  <= EMPTY;
            idx_q <= '0;
            res_q <= '0;
        end else if (cap_vld) begin
            st_q  <= DRAIN;
            idx_q <= '0;
            res_q <= cap_dat;
        end else if (xfer) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_LANE) begin
                st_q <= EMPTY;
            end
        end
    end

endmodule

// File: rtl/sort_stream_adapter.sv
// Gathers 4 streamed words into a frame for the sort block, kicks it, and streams the sorted lanes back out.
// 4th accept to sort_kick: 1 cycle; sort_busy falling (buffer free) to out_valid: 1 cycle; drain 1 word/cycle.
// in_ready drops from kick until the result is captured; a result waits in HOLD while the previous one drains.
module sort_stream_adapter
    import sort_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    sort_stream_adapter_if.master bus
);

    load_state_t                      state_q;
    load_state_t                      state_d;
    lane_idx_t                        cnt_q;
    logic                             in_rdy_q;
    logic [WIDTH-1:0]                 lane_q [NUM_LANES];
    logic                             accept;
    logic                             cap_vld;
    logic                             cap_rdy;
    logic [NUM_LANES-1:0][WIDTH-1:0]  cap_dat;
    logic [WIDTH-1:0]                 drn_dat;
    logic                             drn_vld;
    logic                             drn_last;

    assign accept = bus.in_valid && in_rdy_q;

    // Load sequencing: collect, kick, follow busy high then low, then hand the result to the drain.
    always_comb begin
        state_d = state_q;
        cap_vld = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (accept && (cnt_q == LAST_LANE)) begin
                    state_d = KICK;
                end
            end
            KICK: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.sort_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.sort_busy) begin
                    if (cap_rdy) begin
                        cap_vld = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // sort outputs stay stable while idle, so capturing late is safe
                if (cap_rdy) begin
                    cap_vld = 1'b1;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State, lane counter and a registered in_ready that stays low while reset is held.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_rdy_q <= (state_d == LOAD);
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Frame registers only move on an accepted word, so they are frozen from kick to capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else if (accept) begin
            lane_q[cnt_q] <= bus.in_data;
        end
    end

    assign bus.in_ready     = in_rdy_q;
    assign bus.sort_kick    = (state_q == KICK);
    assign bus.sort_input_0 = lane_q[0];
    assign bus.sort_input_1 = lane_q[1];
    assign bus.sort_input_2 = lane_q[2];
    assign bus.sort_input_3 = lane_q[3];

    assign cap_dat = {bus.sort_output_3, bus.sort_output_2, bus.sort_output_1, bus.sort_output_0};

    sort_result_drain #(
        .WIDTH (WIDTH)
    ) u_drain (
        .CLK       (CLK),
        .RST       (RST),
        .cap_vld   (cap_vld),
        .cap_dat   (cap_dat),
        .cap_rdy   (cap_rdy),
        .out_data  (drn_dat),
        .out_valid (drn_vld),
        .out_ready (bus.out_ready),
        .out_last  (drn_last)
    );

    assign bus.out_data  = drn_dat;
    assign bus.out_valid = drn_vld;
    assign bus.out_last  = drn_last;

endmodule

// File: doc/sort_stream_adapter.md
# sort_stream_adapter

Upstream/downstream adapter for the 4-lane `sort` block: collects a serial valid/ready word stream into 4-word frames, drives `sort`'s parallel inputs and `kick`, waits on `busy`, captures the sorted lanes and re-serialises them as a valid/ready stream with a last marker. Sits between a streaming producer and `sort`, letting `sort` be used inside stream pipelines. The next frame loads while the previous result drains.

## Interface
- `WIDTH`, 32, data word width; must match `sort` `WIDTH`.
- `CLK` in 1: single clock, all logic on rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `in_data` in WIDTH: upstream word.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: adapter accepts a word; transfer when `in_valid && in_ready`.
- `sort_input_0..3` out WIDTH each: registered frame to `sort` `input_0..3`.
- `sort_kick` out 1: one-cycle start pulse to `sort` `kick`.
- `sort_busy` in 1: from `sort` `busy`.
- `sort_output_0..3` in WIDTH each: from `sort` `output_0..3`.
- `out_data` out WIDTH: sorted word, lane 0 first.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream accepts; transfer when `out_valid && out_ready`.
- `out_last` out 1: high with the 4th word of each frame.

## Operation
- Load FSM, states LOAD, KICK, WAIT_HI, WAIT_LO, HOLD.
- LOAD: `in_ready`=1; accepted word k (k=0..3, 2-bit counter) written to `sort_input_k`; on 4th accept, counter wraps to 0, next state KICK.
- KICK: `sort_kick`=1 for exactly one cycle; `in_ready`=0 → WAIT_HI.
- WAIT_HI: wait `sort_busy`=1 → WAIT_LO. WAIT_LO: wait `sort_busy`=0, then if drain buffer empty capture `sort_output_0..3` into it and go to LOAD, else go to HOLD.
- HOLD: wait until drain buffer empty, capture, go to LOAD. `sort` outputs hold stable while not busy, so delayed capture is valid.
- Drain side: 4-word result buffer plus 2-bit read index; EMPTY/DRAIN flag. DRAIN: `out_valid`=1, `out_data`=buffer[index]; index advances on transfer; `out_last`=(index==3); after 4th transfer → EMPTY.
- Capture and last-word drain in same cycle: buffer counts as empty in that cycle (capture wins, no bubble required but allowed one cycle).
- `sort_input_*` change only in LOAD; unchanged from KICK through capture.
- Back-pressure: `out_ready`=0 holds `out_data`/`out_last` stable; `in_valid`=0 in LOAD stalls the counter.
- No data arithmetic; order is whatever `sort` produces (ascending).

## Timing
- Reset (RST=0) asynchronously: load FSM=LOAD, counters=0, drain EMPTY; `in_ready`=1 once RST high (0 while RST low), `sort_kick`=0, `sort_input_0..3`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
- Reset mid-frame or mid-sort discards partial frame and buffered result; no pulse or transfer emitted on release.
- 4th input accept at cycle t → `sort_kick` high at t+1.
- `sort_busy` falling seen at cycle t (WAIT_LO, buffer empty) → `out_valid` high at t+1.
- Drain throughput 1 word/cycle with `out_ready`=1.
- `in_ready`/`out_valid` are decoded from registered state only; no combinational `in_valid`→`in_ready` or `out_ready`→`out_valid` path.

## Structure
- Package `sort_stream_pkg`: load-state enum (LOAD, KICK, WAIT_HI, WAIT_LO, HOLD), `NUM_LANES`=4, lane-index type (2 bits).
- Sub-module `sort_result_drain`: 4-entry result buffer, read index, EMPTY/DRAIN flag, capture input, stream output. Load FSM stays in top.

## Test plan
- Bench instantiates `sort_stream_adapter` + `sort`, WIDTH=32.
- Single frame: stream 4,3,2,1 with `out_ready`=1 → exactly one `sort_kick` pulse 1 cycle after 4th accept; out 1,2,3,4, `out_last` only on 4.
- Back-pressure: frame 9,7,8,5, `out_ready` toggled 1/0 each cycle → out 5,7,8,9, values stable while stalled, 4 transfers total.
- Overlap: frames {40,30,20,10},{4,3,2,1} back-to-back, `out_ready`=0 for 20 cycles → first frame held in buffer, second reaches HOLD, `in_ready`=0 in HOLD; release → 10,20,30,40 then 1,2,3,4.
- Input bubbles: `in_valid` low between each word of 2,2,1,1 → kick only after 4th accept; out 1,1,2,2.
- Reset mid-sort: assert RST low in WAIT_LO after frame 4,3,2,1 → all outputs 0 immediately; after release no output; next frame 8,6,7,5 → out 5,6,7,8.
